// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the MDIO request arbiter and its neighbours:
//   - MDIO opcode constants (OP_WRITE, OP_READ)
//   - arbiter FSM state encoding (IDLE, ISSUE, WAIT_DONE, RESP)
//   - MDIO field widths (PHY_W, REG_W, DATA_W, OP_W)
//   - op_is_legal(): true for the two opcodes the engine understands
// -----------------------------------------------------------------------------
package mdio_pkg;

    localparam int PHY_W  = 5;
    localparam int REG_W  = 5;
    localparam int DATA_W = 16;
    localparam int OP_W   = 2;

    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
    localparam logic [OP_W-1:0] OP_READ  = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } arb_state_e;

    // Only write and read frames are ever handed to the engine.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/mdio_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// mdio_req_arbiter_if
// Bundles the requester-side and engine-side signals of mdio_req_arbiter.
//   Requester side : req_valid/op/phy/reg/wdata in, req_ack, resp_valid,
//                    resp_rdata, resp_err out (per-requester fields flattened)
//   Engine side    : eng_start/op/phy/reg/wdata out, eng_busy, eng_done,
//                    eng_rdata in
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings (requesters plus the MDIO station engine)
// -----------------------------------------------------------------------------
interface mdio_req_arbiter_if
    import mdio_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [OP_W*NUM_REQ-1:0]   req_op;
    logic [PHY_W*NUM_REQ-1:0]  req_phy;
    logic [REG_W*NUM_REQ-1:0]  req_reg;
    logic [DATA_W*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_rdata;
    logic                      resp_err;

    logic                      eng_start;
    logic [OP_W-1:0]           eng_op;
    logic [PHY_W-1:0]          eng_phy;
    logic [REG_W-1:0]          eng_reg;
    logic [DATA_W-1:0]         eng_wdata;
    logic                      eng_busy;
    logic                      eng_done;
    logic [DATA_W-1:0]         eng_rdata;

    modport slave (
        input  req_valid, req_op, req_phy, req_reg, req_wdata,
        output req_ack, resp_valid, resp_rdata, resp_err,
        output eng_start, eng_op, eng_phy, eng_reg, eng_wdata,
        input  eng_busy, eng_done, eng_rdata
    );

    modport master (
        output req_valid, req_op, req_phy, req_reg, req_wdata,
        input  req_ack, resp_valid, resp_rdata, resp_err,
        input  eng_start, eng_op, eng_phy, eng_reg, eng_wdata,
        output eng_busy, eng_done, eng_rdata
    );

endinterface

// File: rtl/mdio_req_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req       in  NUM_REQ  request bits
//   rr_ptr    in  IDX_W    index of the last winner
//   grant_oh  out NUM_REQ  one-hot grant (zero when no request)
//   grant_idx out IDX_W    index of the granted bit
//   grant_any out 1        at least one request is set
// The search starts at rr_ptr+1 and wraps modulo NUM_REQ, so the last
// winner is considered last.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int               cand_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic             hit_s;

    // Walk the candidates in priority order; the first set bit wins.
    always_comb begin
        grant_oh   = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        hit_s      = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s                = (int'(rr_ptr) + i) % NUM_REQ;
            cand_idx_s            = IDX_W'(cand_s);
            hit_s                 = req[cand_idx_s] & ~grant_any;
            grant_oh[cand_idx_s]  = grant_oh[cand_idx_s] | hit_s;
            grant_idx             = hit_s ? cand_idx_s : grant_idx;
            grant_any             = grant_any | hit_s;
        end
    end

endmodule

// File: rtl/mdio_req_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_req_arbiter
// Shares one MDIO station engine between NUM_REQ management requesters.
// Round-robin grant, command latch, single eng_start pulse, wait for
// eng_done, then a one-cycle response to the winning requester only.
// Exactly one frame is outstanding at any time.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   bus    mdio_req_arbiter_if.slave (requester and engine signals)
//
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   TIMEOUT_CYCLES WAIT_DONE cycle limit (timeout build only)
//
// Build option:
//   MDIO_ARB_TIMEOUT_EN - when defined, WAIT_DONE gives up after
//   TIMEOUT_CYCLES cycles and returns an error response. When undefined,
//   WAIT_DONE waits for eng_done indefinitely.
//
// All outputs are registered. Timing with an idle arbiter (eng_busy = 0):
// req_valid seen in cycle 0 -> req_ack in cycle 1 -> eng_start in cycle 2;
// resp_valid follows eng_done by one cycle. An illegal opcode skips the
// engine: req_ack in cycle 1, error response in cycle 2.
// -----------------------------------------------------------------------------
module mdio_req_arbiter
    import mdio_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    mdio_req_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef MDIO_ARB_TIMEOUT_EN
    localparam int               CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]            wait_cnt_r;
`endif

    // Arbitration results.
    logic [NUM_REQ-1:0] grant_oh_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_any_s;

    // Winner's command fields, muxed out of the flattened request buses.
    logic [OP_W-1:0]    sel_op_s;
    logic [PHY_W-1:0]   sel_phy_s;
    logic [REG_W-1:0]   sel_reg_s;
    logic [DATA_W-1:0]  sel_wdata_s;

    // State and registered outputs.
    arb_state_e         state_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [NUM_REQ-1:0] grant_oh_r;
    logic               illegal_r;
    logic [NUM_REQ-1:0] req_ack_r;
    logic [NUM_REQ-1:0] resp_valid_r;
    logic [DATA_W-1:0]  resp_rdata_r;
    logic               resp_err_r;
    logic               eng_start_r;
    logic [OP_W-1:0]    eng_op_r;
    logic [PHY_W-1:0]   eng_phy_r;
    logic [REG_W-1:0]   eng_reg_r;
    logic [DATA_W-1:0]  eng_wdata_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant_oh  (grant_oh_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Select the candidate winner's command fields.
    always_comb begin
        sel_op_s    = bus.req_op   [int'(grant_idx_s)*OP_W   +: OP_W];
        sel_phy_s   = bus.req_phy  [int'(grant_idx_s)*PHY_W  +: PHY_W];
        sel_reg_s   = bus.req_reg  [int'(grant_idx_s)*REG_W  +: REG_W];
        sel_wdata_s = bus.req_wdata[int'(grant_idx_s)*DATA_W +: DATA_W];
    end

    // Arbiter FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            rr_ptr_r     <= IDX_W'(NUM_REQ - 1);
            grant_oh_r   <= '0;
            illegal_r    <= 1'b0;
            req_ack_r    <= '0;
            resp_valid_r <= '0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            eng_start_r  <= 1'b0;
            eng_op_r     <= '0;
            eng_phy_r    <= '0;
            eng_reg_r    <= '0;
            eng_wdata_r  <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
            wait_cnt_r   <= '0;
`endif
        end else begin
            req_ack_r    <= '0;
            resp_valid_r <= '0;
            eng_start_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A busy engine (e.g. a stale frame after a timeout) blocks any grant.
                    if (grant_any_s && !bus.eng_busy) begin
                        grant_oh_r  <= grant_oh_s;
                        rr_ptr_r    <= grant_idx_s;
                        req_ack_r   <= grant_oh_s;
                        eng_op_r    <= sel_op_s;
                        eng_phy_r   <= sel_phy_s;
                        eng_reg_r   <= sel_reg_s;
                        eng_wdata_r <= sel_wdata_s;
                        if (op_is_legal(sel_op_s)) begin
                            illegal_r <= 1'b0;
                            state_r   <= ISSUE;
                        end else begin
                            illegal_r <= 1'b1;
                            state_r   <= RESP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    eng_start_r <= 1'b1;
`ifdef MDIO_ARB_TIMEOUT_EN
                    wait_cnt_r  <= '0;
`endif
                    state_r     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // eng_done is checked first so it wins over a coincident timeout.
                    if (bus.eng_done) begin
                        resp_valid_r <= grant_oh_r;
                        resp_rdata_r <= (eng_op_r == OP_READ) ? bus.eng_rdata : {DATA_W{1'b0}};
                        resp_err_r   <= 1'b0;
                        state_r      <= RESP;
                    end
`ifdef MDIO_ARB_TIMEOUT_EN
                    else if (wait_cnt_r == TO_LAST) begin
                        resp_valid_r <= grant_oh_r;
                        resp_rdata_r <= {DATA_W{1'b0}};
                        resp_err_r   <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        state_r    <= WAIT_DONE;
                    end
`else
                    else begin
                        state_r <= WAIT_DONE;
                    end
`endif
                end
                RESP: begin
                    // Engine responses were already pulsed on entry; an illegal
                    // opcode gets its error pulse here, one cycle after req_ack.
                    if (illegal_r) begin
                        resp_valid_r <= grant_oh_r;
                        resp_rdata_r <= {DATA_W{1'b0}};
                        resp_err_r   <= 1'b1;
                        illegal_r    <= 1'b0;
                    end else begin
                        illegal_r    <= 1'b0;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack    = req_ack_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.eng_start  = eng_start_r;
    assign bus.eng_op     = eng_op_r;
    assign bus.eng_phy    = eng_phy_r;
    assign bus.eng_reg    = eng_reg_r;
    assign bus.eng_wdata  = eng_wdata_r;

endmodule

// File: tb/tb_mdio_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mdio_req_arbiter
// Directed, self-checking bench for mdio_req_arbiter (NUM_REQ = 4,
// TIMEOUT_CYCLES = 16). Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, so each step() is one clock cycle.
// -----------------------------------------------------------------------------
module tb_mdio_req_arbiter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mdio_req_arbiter_if #(.NUM_REQ(4)) bus ();

    mdio_req_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd);
        bus.req_op[2*i +: 2]     = op;
        bus.req_phy[5*i +: 5]    = phy;
        bus.req_reg[5*i +: 5]    = rg;
        bus.req_wdata[16*i +: 16] = wd;
    endtask

    // Bounded wait for any req_ack, then compare against the expected one-hot.
    task automatic wait_ack(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (bus.req_ack == 4'b0000 && n < 30) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.req_ack), 32'(exp));
    endtask

    // Pulse eng_done for one cycle with the given read data.
    task automatic frame_done(input logic [15:0] rd);
        bus.eng_done  = 1'b1;
        bus.eng_rdata = rd;
        step();
        bus.eng_done  = 1'b0;
        bus.eng_rdata = 16'h0000;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   32'(bus.req_ack),    32'h0);
        chk({tag, "_resp"},  32'(bus.resp_valid), 32'h0);
        chk({tag, "_rdata"}, 32'(bus.resp_rdata), 32'h0);
        chk({tag, "_err"},   32'(bus.resp_err),   32'h0);
        chk({tag, "_start"}, 32'(bus.eng_start),  32'h0);
        chk({tag, "_op"},    32'(bus.eng_op),     32'h0);
        chk({tag, "_phy"},   32'(bus.eng_phy),    32'h0);
    endtask

    initial begin
        logic [3:0] exp_oh;
        int         resp_cnt [4];
        logic       seen;

        vectors     = 0;
        miscompares = 0;
        reset         = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_op    = 8'h00;
        bus.req_phy   = 20'h0;
        bus.req_reg   = 20'h0;
        bus.req_wdata = 64'h0;
        bus.eng_busy  = 1'b0;
        bus.eng_done  = 1'b0;
        bus.eng_rdata = 16'h0000;

        // ---- reset state ----
        step();
        step();
        reset = 1'b0;
        chk_all_zero("reset");

        // ---- single read on requester 0 ----
        set_req(0, 2'b10, 5'h01, 5'h01, 16'h0000);
        bus.req_valid = 4'b0001;
        step();                                   // cycle 1
        chk("rd_ack_c1", 32'(bus.req_ack), 32'h1);
        chk("rd_start_c1", 32'(bus.eng_start), 32'h0);
        bus.req_valid = 4'b0000;
        step();                                   // cycle 2
        chk("rd_start_c2", 32'(bus.eng_start), 32'h1);
        chk("rd_eng_phy", 32'(bus.eng_phy), 32'h01);
        chk("rd_eng_reg", 32'(bus.eng_reg), 32'h01);
        chk("rd_eng_op", 32'(bus.eng_op), 32'h2);
        step();
        chk("rd_start_c3", 32'(bus.eng_start), 32'h0);
        frame_done(16'h796D);
        chk("rd_resp", 32'(bus.resp_valid), 32'h1);
        chk("rd_rdata", 32'(bus.resp_rdata), 32'h796D);
        chk("rd_err", 32'(bus.resp_err), 32'h0);
        step();
        chk("rd_resp_pulse", 32'(bus.resp_valid), 32'h0);
        chk("rd_rdata_hold", 32'(bus.resp_rdata), 32'h796D);

        // ---- contention from reset: order 0,1,2,3,0 ----
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 2'b10, 5'(i + 4), 5'(i), 16'h0000);
            resp_cnt[i] = 0;
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            wait_ack($sformatf("rr_ack%0d", k), exp_oh);
            step();
            chk($sformatf("rr_start%0d", k), 32'(bus.eng_start), 32'h1);
            chk($sformatf("rr_phy%0d", k), 32'(bus.eng_phy), 32'((k % 4) + 4));
            for (int j = 0; j < 9; j++) step();
            frame_done(16'hA000 + 16'(k));
            chk($sformatf("rr_resp%0d", k), 32'(bus.resp_valid), 32'(exp_oh));
            chk($sformatf("rr_rdata%0d", k), 32'(bus.resp_rdata), 32'hA000 + 32'(k));
            if (k < 4) begin
                for (int i = 0; i < 4; i++) resp_cnt[i] += int'(bus.resp_valid[i]);
            end
        end
        for (int i = 0; i < 4; i++) chk($sformatf("rr_round_cnt%0d", i), 32'(resp_cnt[i]), 32'h1);
        bus.req_valid = 4'b0000;
        step();

        // ---- illegal opcode on requester 2 ----
        set_req(2, 2'b00, 5'h02, 5'h02, 16'h0000);
        bus.req_valid = 4'b0100;
        wait_ack("ill_ack", 4'b0100);
        bus.req_valid = 4'b0000;
        seen = bus.eng_start;
        step();
        seen = seen | bus.eng_start;
        chk("ill_resp", 32'(bus.resp_valid), 32'h4);
        chk("ill_err", 32'(bus.resp_err), 32'h1);
        chk("ill_rdata", 32'(bus.resp_rdata), 32'h0);
        for (int j = 0; j < 4; j++) begin
            step();
            seen = seen | bus.eng_start;
        end
        chk("ill_no_start", 32'(seen), 32'h0);

        // ---- eng_busy blocks the grant ----
        set_req(1, 2'b10, 5'h02, 5'h03, 16'h0000);
        bus.eng_busy  = 1'b1;
        bus.req_valid = 4'b0010;
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            seen = seen | (bus.req_ack != 4'b0000);
        end
        chk("busy_no_ack", 32'(seen), 32'h0);
        bus.eng_busy = 1'b0;
        step();
        chk("busy_ack", 32'(bus.req_ack), 32'h2);
        bus.req_valid = 4'b0000;
        step();
        chk("busy_start", 32'(bus.eng_start), 32'h1);
        step();
        frame_done(16'h1234);
        chk("busy_resp", 32'(bus.resp_valid), 32'h2);
        chk("busy_rdata", 32'(bus.resp_rdata), 32'h1234);

        // ---- write on requester 3: rdata must read back 0 ----
        set_req(3, 2'b01, 5'h03, 5'h07, 16'hBEEF);
        bus.req_valid = 4'b1000;
        wait_ack("wr_ack", 4'b1000);
        bus.req_valid = 4'b0000;
        step();
        chk("wr_start", 32'(bus.eng_start), 32'h1);
        chk("wr_wdata", 32'(bus.eng_wdata), 32'hBEEF);
        chk("wr_op", 32'(bus.eng_op), 32'h1);
        chk("wr_reg", 32'(bus.eng_reg), 32'h07);
        step();
        frame_done(16'hFFFF);
        chk("wr_resp", 32'(bus.resp_valid), 32'h8);
        chk("wr_rdata", 32'(bus.resp_rdata), 32'h0);
        chk("wr_err", 32'(bus.resp_err), 32'h0);
        step();
        chk("wr_op_hold", 32'(bus.eng_op), 32'h1);

        // ---- reset in WAIT_DONE, stray eng_done, next grant to requester 0 ----
        set_req(2, 2'b10, 5'h09, 5'h09, 16'h0000);
        bus.req_valid = 4'b0100;
        wait_ack("rst_ack", 4'b0100);
        bus.req_valid = 4'b0000;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("rst_mid");
        frame_done(16'h5555);
        chk("rst_stray_resp", 32'(bus.resp_valid), 32'h0);
        chk("rst_stray_rdata", 32'(bus.resp_rdata), 32'h0);
        set_req(0, 2'b10, 5'h01, 5'h02, 16'h0000);
        set_req(3, 2'b10, 5'h03, 5'h04, 16'h0000);
        bus.req_valid = 4'b1001;
        step();
        chk("rst_next_ack", 32'(bus.req_ack), 32'h1);
        bus.req_valid = 4'b0000;
        step();
        step();
        frame_done(16'h0F0F);
        chk("rst_next_resp", 32'(bus.resp_valid), 32'h1);

        // ---- engine never finishes ----
        set_req(1, 2'b10, 5'h11, 5'h12, 16'h0000);
        bus.req_valid = 4'b0010;
        wait_ack("to_ack", 4'b0010);
        bus.req_valid = 4'b0000;
        step();                                   // WAIT_DONE entry cycle
        chk("to_start", 32'(bus.eng_start), 32'h1);
        bus.eng_busy = 1'b1;
`ifdef MDIO_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (int j = 0; j < 15; j++) begin
            step();
            seen = seen | (bus.resp_valid != 4'b0000);
        end
        chk("to_early", 32'(seen), 32'h0);
        step();                                   // entry + 16
        chk("to_resp", 32'(bus.resp_valid), 32'h2);
        chk("to_err", 32'(bus.resp_err), 32'h1);
        chk("to_rdata", 32'(bus.resp_rdata), 32'h0);
        bus.req_valid = 4'b0001;
        seen = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            seen = seen | (bus.req_ack != 4'b0000);
        end
        chk("to_busy_no_ack", 32'(seen), 32'h0);
        bus.eng_busy = 1'b0;
        step();
        chk("to_busy_ack", 32'(bus.req_ack), 32'h1);
        bus.req_valid = 4'b0000;
        step();
        step();
        frame_done(16'h2222);
        chk("to_next_resp", 32'(bus.resp_valid), 32'h1);
`else
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            step();
            seen = seen | (bus.resp_valid != 4'b0000);
        end
        chk("nto_no_resp", 32'(seen), 32'h0);
        bus.eng_busy = 1'b0;
        frame_done(16'h3C3C);
        chk("nto_resp", 32'(bus.resp_valid), 32'h2);
        chk("nto_err", 32'(bus.resp_err), 32'h0);
        chk("nto_rdata", 32'(bus.resp_rdata), 32'h3C3C);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdio_req_arbiter.md
Name: mdio_req_arbiter

Overview:
Shares one MDIO station engine (the MDC/MDIO shifter) between NUM_REQ management requesters, for example per-port PHY pollers and the host register interface. It arbitrates round-robin, latches the winner's command, and issues a single start pulse to the engine. It waits for engine completion, then returns read data and status to the winning requester only. Only one MDIO frame is ever outstanding.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT_DONE before an error response (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held until req_ack
req_op  in  2*NUM_REQ  per-requester opcode: 01 = write, 10 = read, others illegal
req_phy  in  5*NUM_REQ  PHY address
req_reg  in  5*NUM_REQ  register address
req_wdata  in  16*NUM_REQ  write data
req_ack  out  NUM_REQ  one-hot, 1-cycle pulse; the request has been latched
resp_valid  out  NUM_REQ  one-hot, 1-cycle pulse; the response is ready
resp_rdata  out  16  read data, valid only with resp_valid
resp_err  out  1  error flag, valid only with resp_valid
eng_start  out  1  1-cycle pulse that starts an engine frame
eng_op  out  2  latched opcode
eng_phy  out  5  latched PHY address
eng_reg  out  5  latched register address
eng_wdata  out  16  latched write data
eng_busy  in  1  engine is shifting a frame
eng_done  in  1  1-cycle pulse at the end of a frame
eng_rdata  in  16  engine read data, valid with eng_done

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; every output = 0; rr_ptr = NUM_REQ-1, so requester 0 has first priority.
- State IDLE:
  - If any req_valid bit is set and eng_busy = 0, grant the first set bit, searching upward from rr_ptr+1 and wrapping modulo NUM_REQ.
  - Latch op/phy/reg/wdata and the grant index. Set rr_ptr to the grant index.
  - Pulse req_ack[grant] in the next cycle.
  - Legal op: go to ISSUE. Illegal op: go to RESP with err = 1, and the engine is not started.
- State ISSUE: pulse eng_start for one cycle while the eng_* buses hold the latched values. Go to WAIT_DONE.
- State WAIT_DONE: on eng_done, capture eng_rdata, set err = 0 and go to RESP.
- State RESP: pulse resp_valid[grant] for one cycle with resp_rdata and resp_err. Go to IDLE.
- resp_rdata:
  - Holds the captured eng_rdata for reads.
  - Is 0 for writes and for error responses.
  - Holds its value between pulses.
- eng_* buses hold their values from ISSUE until the next grant.
- Latency with idle arbiter and eng_busy = 0, where req_valid rises at cycle 0:
  - req_ack at cycle 1.
  - eng_start at cycle 2.
  - resp_valid one cycle after eng_done.
- Simultaneous requests: strict round-robin. A requester that keeps req_valid high waits at most NUM_REQ-1 grants.
- A requester dropping req_valid before req_ack withdraws its request; this is legal.
- Changing req_* fields while waiting for req_ack is legal; the fields are sampled only in the grant cycle.
- eng_done outside WAIT_DONE is ignored.
- eng_busy = 1 in IDLE blocks any grant, for example while a stale frame finishes after a timeout.
- reset mid-transaction returns to IDLE at once with no response pulse; the pending requester must re-request.

Optional Feature:
MDIO_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 without eng_done, go to RESP with resp_err = 1 and resp_rdata = 0.
  - If eng_done and the timeout occur in the same cycle, eng_done wins and the response has err = 0.
- Undefined: no counter exists, and WAIT_DONE waits indefinitely for eng_done.

Decomposition:
Shared package mdio_pkg holds:
- The opcode constants OP_WRITE = 2'b01 and OP_READ = 2'b10.
- The state encodings IDLE, ISSUE, WAIT_DONE, RESP.
- The field widths PHY_W = 5, REG_W = 5, DATA_W = 16.

One sub-module, rr_arbiter: inputs NUM_REQ request bits and rr_ptr; output is a one-hot grant plus an index. It is purely combinational and reusable elsewhere.

Test Plan:
- Single read: req_valid = 0001, op = 10, phy = 5'h01, reg = 5'h01 → req_ack = 0001 at cycle 1; eng_start at cycle 2 with eng_phy = 01, eng_reg = 01; after eng_done with eng_rdata = 16'h796D → resp_valid = 0001, resp_rdata = 796D, resp_err = 0.
- Contention: req_valid = 1111 held with engine done latency 10 cycles → grant order 0,1,2,3,0; each requester gets exactly one resp_valid per round.
- Illegal op: op = 00 on requester 2 → req_ack = 0100, then resp_valid = 0100 with err = 1 and rdata = 0; eng_start never pulses.
- eng_busy held at 1 in IDLE with req_valid = 0010 → no req_ack until eng_busy falls; req_ack follows 1 cycle later.
- Reset in WAIT_DONE: assert reset for 1 cycle → all outputs 0, no resp_valid; a later stray eng_done is ignored and the next request is granted to requester 0.
- MDIO_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and eng_done never asserted → resp_valid 16 cycles after WAIT_DONE entry with err = 1; the next grant waits for eng_busy = 0.
